// File: rtl/sha256_compress.sv
// SHA-256 compression core: 64 rounds over a..h fed one schedule word per cycle,
// then the working variables are folded into the chaining hash H0..H7.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first_block,
    input  logic         w_valid,
    input  logic [31:0]  w_in,
    output logic         busy,
    output logic         done,
    output logic [6:0]   round_out,
    output logic [255:0] digest
);

    // state | meaning
    // IDLE  | waiting for start; hash holds the last digest
    // ROUND | one round per valid schedule word, stalls while w_valid=0
    // FINAL | fold a..h into hash, raise done on the following cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        done_q;
    logic [6:0]  round;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] hash [8];

    logic [31:0] sum0, sum1, ch, maj, k_cur, t1, t2;

    always_comb begin
        sum0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        sum1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch    = (e & f) ^ (~e & g);
        maj   = (a & b) ^ (a & c) ^ (b & c);
        k_cur = K[round[5:0]];
        t1    = h + sum1 + ch + k_cur + w_in;
        t2    = sum0 + maj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROUND;
            ROUND:   if (w_valid && (round == 7'd63)) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            round  <= 7'd0;
            a <= '0; b <= '0; c <= '0; d <= '0;
            e <= '0; f <= '0; g <= '0; h <= '0;
            for (int i = 0; i < 8; i++) hash[i] <= IV[i];
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round <= 7'd0;
                        if (first_block) begin
                            for (int i = 0; i < 8; i++) hash[i] <= IV[i];
                            a <= IV[0]; b <= IV[1]; c <= IV[2]; d <= IV[3];
                            e <= IV[4]; f <= IV[5]; g <= IV[6]; h <= IV[7];
                        end else begin
                            a <= hash[0]; b <= hash[1]; c <= hash[2]; d <= hash[3];
                            e <= hash[4]; f <= hash[5]; g <= hash[6]; h <= hash[7];
                        end
                    end
                end
                ROUND: begin
                    if (w_valid) begin
                        round <= round + 7'd1;
                        h <= g;
                        g <= f;
                        f <= e;
                        e <= d + t1;
                        d <= c;
                        c <= b;
                        b <= a;
                        a <= t1 + t2;
                    end
                end
                FINAL: begin
                    hash[0] <= hash[0] + a;
                    hash[1] <= hash[1] + b;
                    hash[2] <= hash[2] + c;
                    hash[3] <= hash[3] + d;
                    hash[4] <= hash[4] + e;
                    hash[5] <= hash[5] + f;
                    hash[6] <= hash[6] + g;
                    hash[7] <= hash[7] + h;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // done is registered, so it rises in the first IDLE cycle together with busy falling
    always_comb begin
        busy      = (state != IDLE);
        done      = done_q;
        round_out = round;
    end

    assign digest = {hash[0], hash[1], hash[2], hash[3],
                     hash[4], hash[5], hash[6], hash[7]};

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression core that consumes the 64 message-schedule words W0..W63, one per cycle, from the message scheduler directly upstream. It runs the 64 rounds on working registers a..h using the K constant table, then folds the result into the chaining hash H0..H7. Multi-block messages chain through the held H value. The final digest goes to the output/host interface stage.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- start  in  1  pulse; begin one 512-bit block; accepted only in IDLE
- first_block  in  1  sampled with accepted start; 1 = load IV into H before the block, 0 = chain from current H
- w_valid  in  1  w_in holds the next schedule word
- w_in  in  32  schedule word W[t], presented in order t = 0..63
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse; digest updated for this block
- round_out  out  7  index of the next W expected (0..63); 64 after the last round
- digest  out  256  {H0,H1,...,H7}, with H0 in [255:224]

## Operation
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - On start=1, latch first_block.
  - If first_block=1, write IV to H0..H7 (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and load a..h from IV.
  - Otherwise load a..h from H.
  - Set round=0, busy=1, go to ROUND.
  - w_valid is ignored in IDLE.
- ROUND: each cycle with w_valid=1, apply one round using K[round] and w_in:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[round] + w_in
  - T2 = Σ0(a) + Maj(a,b,c)
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - round increments.
- ROUND with w_valid=0: all state holds (stall). There is no limit on stall length.
- After the round with round=63 is consumed: round becomes 64, go to FINAL. w_valid is ignored from this point.
- FINAL: Hi ← Hi + working var i for every i, done=1 for this one cycle, busy=0, go to IDLE.
- Arithmetic: all adds are 32-bit modulo 2^32, carries discarded.
- K: 64-entry constant ROM of the FIPS 180-4 values, indexed by round[5:0].
- start while busy: ignored, no effect on the block in progress.
- start in the same cycle as FINAL: ignored. The earliest acceptable start is the cycle after done.
- digest is driven continuously from H. It changes only in FINAL, on accepted start with first_block=1, or on reset.

## Timing
- Reset values: state=IDLE, busy=0, done=0, round_out=0, a..h=0, H=IV. After reset, digest = IV concatenation.
- rst wins over every other input in the same cycle. Reset mid-block aborts the block; H returns to IV and the partial result is discarded.
- Latency with no stalls:
  - start is sampled at edge E0.
  - Rounds occur at edges E1..E64.
  - FINAL at edge E65: done=1 and the new digest are visible after E65.
  - Each w_valid=0 cycle during ROUND adds exactly one cycle.
- busy: rises after E0 and falls after E65, in the same cycle done rises.
- round_out: equals round, a registered value, in every state.

## Test plan
- Reset: hold rst for 2 cycles with random other inputs -> busy=0, done=0, round_out=0, digest=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
- "abc", first_block=1:
  - Stimulus: W0=61626380, W1..W14=0, W15=00000018, W16..63 from the reference schedule model; w_valid held high.
  - Required: done exactly 65 cycles after start, digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message:
  - Stimulus: W0=80000000, rest of W0..W15=0, random w_valid stalls (~30%).
  - Required: digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; done delay = 65 + number of stall cycles.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: block 1 with first_block=1, block 2 with first_block=0.
  - Required: after the first done, digest = intermediate model value; after the second, 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Protocol abuse:
  - start pulsed at round 10 and in the FINAL cycle -> ignored; digest still matches "abc".
  - w_valid pulses in IDLE -> no state change.
- Reset mid-operation: assert rst at round 30, then rerun "abc" -> correct "abc" digest, no residue from the aborted block.
